csel_adder_pipe: RTL and testbench
==================================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor with valid/ready handshake on both sides.
- Operand width is split into BLOCK_W-bit carry-select blocks. Each pipeline stage resolves BLK_PER_STG blocks using the carry registered by the previous stage.
- Sits in the datapath wherever a wide add/sub is needed at full clock rate.
- Adds subtract mode, signed overflow and flow control, none of which the fixed 4-bit carry-select cell provides.

Parameters:
- WIDTH, 16, operand/result width in bits.
- BLOCK_W, 4, bits per carry-select block.
- BLK_PER_STG, 1, carry-select blocks resolved per pipeline stage.
- Derived (localparam): NUM_STG = WIDTH/(BLOCK_W*BLK_PER_STG); this is also the latency.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add mode only)
- sub  in  1  1 = subtract (a - b)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB
- ovf  out  1  signed (two's complement) overflow

Behaviour:
- Elaboration check: WIDTH % (BLOCK_W*BLK_PER_STG) == 0 and NUM_STG >= 1. Otherwise $error.
- Operand conditioning at input:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : cin (cin is ignored when sub=1)
- Global enable: en = !out_valid || out_ready; in_ready = en && !rst.
- Accept rule: a transfer occurs when in_valid && in_ready. All stage registers shift when en=1.
- A stage register's valid bit loads its predecessor's valid, or in_valid && in_ready at stage 0.
- Pipeline structure:
  - Stage k resolves blocks k*BLK_PER_STG .. (k+1)*BLK_PER_STG-1.
  - Within a stage, each block computes the sums for carry 0 and carry 1, then selects by the incoming carry. Blocks inside one stage chain combinationally.
  - Unresolved operand slices travel skewed forward. Resolved sum slices travel forward de-skewed, so all WIDTH bits of one transaction emerge together.
- Latency: NUM_STG cycles from the accept edge to out_valid=1, with out_ready held high. Throughput is 1 result per cycle.
- Bubbles are not collapsed: an empty slot shifts like data.
- Output: sum, cout and ovf come directly from the final stage registers.
  - cout = carry out of bit WIDTH-1. In sub mode, cout=1 means no borrow.
  - ovf = carry into bit WIDTH-1 XOR cout, where carry into MSB = a[W-1]^b_eff[W-1]^sum[W-1].
- Stall: while out_valid=1 and out_ready=0:
  - sum, cout and ovf are held stable.
  - in_ready=0 and no stage moves.
  - No transaction is lost or duplicated.
- Simultaneous events: an output handshake and an input accept in the same cycle are legal. The pipeline shifts once.
- Ordering: results come out in strict acceptance order.
- Reset, applied at the rising edge with rst=1:
  - All stage valids become 0; out_valid becomes 0.
  - sum, cout and ovf become 0; all data registers become 0.
  - in_ready is 0 while rst=1 and returns to 1 on the first cycle after rst deasserts.
- Reset mid-operation: in-flight transactions are discarded. No out_valid pulse for them ever appears.

Decomposition:
- Shared package csel_pkg holds:
  - default WIDTH/BLOCK_W/BLK_PER_STG constants
  - function num_stg(width, block_w, blk_per_stg)
  - function signed_ovf(a_msb, b_msb, s_msb, cout)
- Sub-module csel_block:
  - parameter BLOCK_W
  - inputs a, b, carry
  - outputs sum, carry_out
  - implements the dual-sum select internally
  - replicated NUM_STG*BLK_PER_STG times by generate.
- All pipeline registers and the handshake live in csel_adder_pipe.

Test Plan (WIDTH=16, BLOCK_W=4, BLK_PER_STG=1, NUM_STG=4, out_ready=1 unless stated):
1. Add 0x00FF+0x0001, cin=0, sub=0 → after exactly 4 cycles: sum=0x0100, cout=0, ovf=0, one out_valid pulse.
2. Add 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0 (carry crosses all 4 stages); 0x7FFF+0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
3. Subtract 0x0005-0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 → sum=0x7FFF, cout=1, ovf=1.
4. Stream 8 back-to-back transactions (a=i, b=0x1000*i, i=0..7), drop out_ready for cycles 6–8 → outputs and in_ready hold during the stall, in_ready=0 throughout, all 8 results arrive in order, e.g. i=3 → sum=0x3003.
5. Reset with 3 transactions in flight → next cycle out_valid=0, sum=0x0000; no out_valid appears before a new accept; in_ready=1 on the first cycle after rst deasserts.
6. Idle bubble: accept one transaction, idle 2 cycles, accept one more → out_valid pulses at cycles 4 and 7 relative to the first accept, with correct data.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package csel_pkg;

  localparam int CSEL_WIDTH       = 16;
  localparam int CSEL_BLOCK_W     = 4;
  localparam int CSEL_BLK_PER_STG = 1;

  // Pipeline depth (and latency) for a given block split.
  function automatic int num_stg(int width, int block_w, int blk_per_stg);
    return width / (block_w * blk_per_stg);
  endfunction

  // Two's complement overflow: carry into MSB xor carry out of MSB.
  function automatic logic signed_ovf(logic a_msb, logic b_msb, logic s_msb, logic cout);
    return (a_msb ^ b_msb ^ s_msb) ^ cout;
  endfunction

  // Bit offset of stage k's skewed operand slice in the flat operand vector.
  // Stage j carries forward width - (j+1)*sw unresolved bits.
  function automatic int op_off(int width, int sw, int k);
    int acc;
    acc = 0;
    for (int j = 0; j < k; j++) acc += width - (j + 1) * sw;
    return acc;
  endfunction

  // Bit offset of stage k's resolved sum slice in the flat sum vector.
  // Stage j holds (j+1)*sw resolved bits.
  function automatic int sum_off(int sw, int k);
    int acc;
    acc = 0;
    for (int j = 0; j < k; j++) acc += (j + 1) * sw;
    return acc;
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: both candidate sums are formed up front and the
// incoming carry only drives the final mux.
module csel_block #(
  parameter int BLOCK_W = 4
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               carry,
  output logic [BLOCK_W-1:0] sum,
  output logic               carry_out
);

  logic [BLOCK_W:0] s0, s1;

  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + (BLOCK_W + 1)'(1);

  // Late select on the resolved carry.
  always_comb {carry_out, sum} = carry ? s1 : s0;

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select add/sub with valid/ready flow control.
// Operands travel skewed (only unresolved slices move on), resolved sum
// slices accumulate de-skewed so the whole result leaves the last stage at once.
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH       = CSEL_WIDTH,
  parameter int BLOCK_W     = CSEL_BLOCK_W,
  parameter int BLK_PER_STG = CSEL_BLK_PER_STG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW      = BLOCK_W * BLK_PER_STG;
  localparam int NUM_STG = num_stg(WIDTH, BLOCK_W, BLK_PER_STG);
  localparam int OPB     = op_off(WIDTH, SW, NUM_STG - 1);
  localparam int OPB_D   = (OPB > 0) ? OPB : 1;
  localparam int SB      = sum_off(SW, NUM_STG);

  if (NUM_STG < 1 || (WIDTH % SW) != 0) begin : g_param_chk
    $error("csel_adder_pipe: WIDTH must be a nonzero multiple of BLOCK_W*BLK_PER_STG");
  end

  logic               en, accept, c0;
  logic [WIDTH-1:0]   b_eff;
  logic [NUM_STG:1]   vld_q;
  logic [NUM_STG:0]   vld_pipe;
  logic [OPB_D-1:0]   op_a, op_b;
  logic [SB-1:0]      sum_w;
  logic [NUM_STG-1:0] c_w;
  logic               ovf_w;

  // One global enable: the whole pipe freezes while the output is blocked.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;
  assign accept   = in_valid && in_ready;
  assign vld_pipe = {vld_q, accept};

  // Subtract is a + ~b + 1; cin is dropped in that mode.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  // Valid shift register; empty slots move exactly like data.
  always_ff @(posedge clk) begin
    if (rst)     vld_q <= '0;
    else if (en) vld_q <= vld_pipe[NUM_STG-1:0];
  end

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    localparam int LO = k * SW;
    localparam int RW = WIDTH - LO;

    logic [RW-1:0]          a_in, b_in;
    logic                   c_in;
    logic [BLK_PER_STG:0]   cc;
    logic [SW-1:0]          s_new;
    logic [LO+SW-1:0]       s_cat, s_q;
    logic                   c_q;

    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = c0;
      assign s_cat = s_new;
    end else begin : g_src
      assign a_in  = op_a[op_off(WIDTH, SW, k - 1) +: RW];
      assign b_in  = op_b[op_off(WIDTH, SW, k - 1) +: RW];
      assign c_in  = c_w[k - 1];
      assign s_cat = {s_new, sum_w[sum_off(SW, k - 1) +: LO]};
    end

    assign cc[0] = c_in;
    for (genvar j = 0; j < BLK_PER_STG; j++) begin : g_blk
      csel_block #(.BLOCK_W(BLOCK_W)) u_blk (
        .a         (a_in[j*BLOCK_W +: BLOCK_W]),
        .b         (b_in[j*BLOCK_W +: BLOCK_W]),
        .carry     (cc[j]),
        .sum       (s_new[j*BLOCK_W +: BLOCK_W]),
        .carry_out (cc[j+1])
      );
    end

    // Resolved sum bits and the carry handed to the next stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        s_q <= s_cat;
        c_q <= cc[BLK_PER_STG];
      end
    end

    assign sum_w[sum_off(SW, k) +: LO + SW] = s_q;
    assign c_w[k] = c_q;

    if (k < NUM_STG - 1) begin : g_ops
      logic [RW-SW-1:0] oa_q, ob_q;

      // Forward only the operand bits later stages still have to add.
      always_ff @(posedge clk) begin
        if (rst) begin
          oa_q <= '0;
          ob_q <= '0;
        end else if (en) begin
          oa_q <= a_in[RW-1:SW];
          ob_q <= b_in[RW-1:SW];
        end
      end

      assign op_a[op_off(WIDTH, SW, k) +: RW - SW] = oa_q;
      assign op_b[op_off(WIDTH, SW, k) +: RW - SW] = ob_q;
    end else begin : g_last
      logic ovf_q;

      // Overflow is settled alongside the top block, where the MSBs are known.
      always_ff @(posedge clk) begin
        if (rst)     ovf_q <= 1'b0;
        else if (en) ovf_q <= signed_ovf(a_in[RW-1], b_in[RW-1], s_new[SW-1], cc[BLK_PER_STG]);
      end

      assign ovf_w = ovf_q;
    end
  end

  if (OPB == 0) begin : g_no_ops
    assign op_a = '0;
    assign op_b = '0;
  end

  assign out_valid = vld_pipe[NUM_STG];
  assign sum       = sum_w[sum_off(SW, NUM_STG - 1) +: WIDTH];
  assign cout      = c_w[NUM_STG-1];
  assign ovf       = ovf_w;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe (WIDTH=16, BLOCK_W=4, BLK_PER_STG=1).
module tb_csel_adder_pipe;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  csel_adder_pipe #(.WIDTH(W), .BLOCK_W(4), .BLK_PER_STG(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference result {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_calc(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic s);
    int sx, sy, ux, uy, r, sr;
    logic co, ov;
    sx = $signed(x); sy = $signed(y);
    ux = int'(x);    uy = int'(y);
    if (s) begin
      r  = ux - uy;
      co = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = ux + uy + int'(ci);
      co = (r > 65535);
      sr = sx + sy + int'(ci);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, r[15:0]};
  endfunction

  // Latency model: N slots, each valid/result; shifts whenever output is free.
  logic        mv[N];
  logic [17:0] mr[N];
  logic        stall_prev;
  logic [17:0] prev_out;
  logic [15:0] got_q[$];
  int          cyc_n = 0;

  // One clock: check pre-edge state against the model, then advance it.
  task automatic cycle(output logic acc);
    logic en, exp_ir;
    #1;
    en     = !mv[N-1] || out_ready;
    exp_ir = en && !rst;
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, mv[N-1]);
    if (mv[N-1]) chk("result", {ovf, cout, sum}, mr[N-1]);
    if (stall_prev) chk("stall_hold", {ovf, cout, sum}, prev_out);
    if (out_valid && out_ready) got_q.push_back(sum);
    stall_prev = mv[N-1] && !out_ready && !rst;
    prev_out   = {ovf, cout, sum};
    acc        = in_valid && exp_ir;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin mv[i] = 1'b0; mr[i] = '0; end
    end else if (en) begin
      for (int i = N - 1; i > 0; i--) begin mv[i] = mv[i-1]; mr[i] = mr[i-1]; end
      mv[0] = acc;
      mr[0] = ref_calc(a, b, cin, sub);
    end
    @(negedge clk);
    cyc_n++;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  vec_t tv[8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   start, tries, rel;

    tv[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tv[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    for (int i = 0; i < N; i++) begin mv[i] = 1'b0; mr[i] = '0; end
    stall_prev = 1'b0;
    prev_out   = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors: single transaction, result exactly 4 cycles later, one pulse
    for (int v = 0; v < 8; v++) begin
      a = tv[v].a; b = tv[v].b; cin = tv[v].cin; sub = tv[v].sub;
      in_valid = 1'b1;
      cycle(acc);
      chk("vec_accept", acc, 1'b1);
      in_valid = 1'b0;
      repeat (N - 1) cycle(acc);
      #1;
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_sum", sum, tv[v].s);
      chk("vec_cout", cout, tv[v].co);
      chk("vec_ovf", ovf, tv[v].ov);
      cycle(acc);
      chk("vec_one_pulse", out_valid, 1'b0);
    end

    // Stream of 8 with out_ready low in cycles 6..8 after the first accept
    got_q.delete();
    start = cyc_n;
    cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 16'(i);
      b = 16'(32'h1000 * i);
      in_valid = 1'b1;
      tries = 0;
      do begin
        rel = cyc_n - start;
        out_ready = !(rel >= 6 && rel <= 8);
        if (rel >= 6 && rel <= 8) begin
          #1;
          chk("stall_in_ready", in_ready, 1'b0);
        end
        cycle(acc);
        tries++;
      end while (!acc && tries < 20);
      if (!acc) chk("stream_accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    tries = 0;
    while (got_q.size() < 8 && tries < 30) begin
      rel = cyc_n - start;
      out_ready = !(rel >= 6 && rel <= 8);
      cycle(acc);
      tries++;
    end
    out_ready = 1'b1;
    chk("stream_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("stream_order", got_q[i], 16'(i + 32'h1000 * i));
      chk("stream_i3", got_q[3], 16'h3003);
    end

    // Reset with 3 transactions in flight
    for (int i = 0; i < 3; i++) begin
      a = 16'(i + 1); b = 16'h0001; in_valid = 1'b1;
      cycle(acc);
      chk("inflight_accept", acc, 1'b1);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle(acc);
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sum", sum, 16'h0000);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("midrst_no_pulse", out_valid, 1'b0);
      cycle(acc);
    end

    // Idle bubble: accepts at relative cycles 0 and 3, outputs at 4 and 7
    for (int r = 0; r <= 8; r++) begin
      in_valid = (r == 0 || r == 3);
      if (r == 0) begin a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; end
      if (r == 3) begin a = 16'hF000; b = 16'h1000; sub = 1'b1; cin = 1'b0; end
      #1;
      chk("bubble_valid", out_valid, (r == 4 || r == 7));
      if (r == 4) chk("bubble_res0", {ovf, cout, sum}, {1'b0, 1'b0, 16'h3333});
      if (r == 7) chk("bubble_res1", {ovf, cout, sum}, {1'b0, 1'b1, 16'hE000});
      cycle(acc);
    end

    // Randomized traffic with backpressure and one reset pulse
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(1));
      sub = 1'($urandom_range(1));
      rst = (i == 200);
      cycle(acc);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 2) cycle(acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
